// File: rtl/ss_capture.sv
// Seven-segment bus capture: debounces each multiplexed digit, decodes it and reassembles a 16-bit frame.
// Optional error counter output is enabled with `define SS_CAPTURE_ERR_CNT_EN.
module ss_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [3:0]  anode_bits_i,
  input  logic [6:0]  cathode_bits_i,
  output logic [15:0] bin_o,
  output logic        valid_o,
`ifdef SS_CAPTURE_ERR_CNT_EN
  output logic        err_o,
  output logic [7:0]  err_cnt_o
`else
  output logic        err_o
`endif
);

  localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);

  logic [10:0] prev_q, prev_d;
  logic [7:0]  stab_cnt_q, stab_cnt_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  captured_q, captured_d;
  logic [15:0] bin_q, bin_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic        same;
  logic        accept;
  logic        anode_ok;
  logic [1:0]  idx;
  logic        dec_ok;
  logic [3:0]  dec_nib;

  always_comb begin
    anode_ok = 1'b1;
    idx      = 2'd0;
    case (anode_bits_i)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: anode_ok = 1'b0;
    endcase
  end

  // Segment patterns are listed g..a, active low.
  always_comb begin
    dec_ok  = 1'b1;
    dec_nib = 4'h0;
    case (cathode_bits_i)
      7'b1000000: dec_nib = 4'h0;
      7'b1111001: dec_nib = 4'h1;
      7'b0100100: dec_nib = 4'h2;
      7'b0110000: dec_nib = 4'h3;
      7'b0011001: dec_nib = 4'h4;
      7'b0010010: dec_nib = 4'h5;
      7'b0000010: dec_nib = 4'h6;
      7'b1111000: dec_nib = 4'h7;
      7'b0000000: dec_nib = 4'h8;
      7'b0010000: dec_nib = 4'h9;
      7'b0001000: dec_nib = 4'hA;
      7'b0000011: dec_nib = 4'hB;
      7'b1000110: dec_nib = 4'hC;
      7'b0100001: dec_nib = 4'hD;
      7'b0000110: dec_nib = 4'hE;
      7'b0001110: dec_nib = 4'hF;
      default:    dec_ok  = 1'b0;
    endcase
  end

  always_comb begin
    prev_d = {anode_bits_i, cathode_bits_i};
    same   = (prev_d == prev_q);
    if (!same)
      stab_cnt_d = 8'd1;
    else if (stab_cnt_q >= STAB_MAX)
      stab_cnt_d = STAB_MAX;
    else
      stab_cnt_d = stab_cnt_q + 8'd1;

    // Fires only on the cycle the count first climbs to the threshold.
    accept = same && (stab_cnt_q == STAB_MAX - 8'd1) && anode_ok;

    shadow_d   = shadow_q;
    captured_d = captured_q;
    bin_d      = bin_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;

    if (accept) begin
      if (dec_ok) begin
        shadow_d[{idx, 2'b00} +: 4] = dec_nib;
        captured_d[idx]             = 1'b1;
      end else begin
        captured_d[idx] = 1'b0;
        err_d           = 1'b1;
      end
    end

    if (captured_d == 4'hF) begin
      bin_d      = shadow_d;
      valid_d    = 1'b1;
      captured_d = 4'h0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_q     <= 11'h7FF;
      stab_cnt_q <= 8'd0;
      shadow_q   <= 16'h0000;
      captured_q <= 4'h0;
      bin_q      <= 16'h0000;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      stab_cnt_q <= stab_cnt_d;
      shadow_q   <= shadow_d;
      captured_q <= captured_d;
      bin_q      <= bin_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign bin_o   = bin_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;

`ifdef SS_CAPTURE_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      err_cnt_q <= 8'd0;
    else if (err_d && (err_cnt_q != 8'hFF))
      err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_ss_capture.sv
// Scoreboard bench for ss_capture: stimulus queues expected valid/err events, a monitor checks them.
module tb_ss_capture;

  localparam int S = 4;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [3:0]  anode_bits_i;
  logic [6:0]  cathode_bits_i;
  logic [15:0] bin_o;
  logic        valid_o;
  logic        err_o;
`ifdef SS_CAPTURE_ERR_CNT_EN
  logic [7:0]  err_cnt_o;
`endif

  ss_capture #(.STABLE_CYCLES(S)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .anode_bits_i   (anode_bits_i),
    .cathode_bits_i (cathode_bits_i),
    .bin_o          (bin_o),
    .valid_o        (valid_o),
`ifdef SS_CAPTURE_ERR_CNT_EN
    .err_o          (err_o),
    .err_cnt_o      (err_cnt_o)
`else
    .err_o          (err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int          kind;   // 1 = valid frame, 2 = decode error
    logic [15:0] bin;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 7'b1000000;  4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;  4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;  4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;  4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;  4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;  4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;  4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;  default: seg = 7'b0001110;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Called at #1 after a rising edge; holds the sample for n cycles.
  task automatic drive_raw(input logic [3:0] an, input logic [6:0] ca, input int n,
                           input int kind, input logic [15:0] exp_bin);
    exp_t e;
    anode_bits_i   = an;
    cathode_bits_i = ca;
    if (kind != 0) begin
      e.kind = kind;
      e.bin  = exp_bin;
      e.cyc  = cyc + S;
      q.push_back(e);
    end
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic drive_digit(input int idx, input logic [6:0] ca, input int n,
                             input int kind, input logic [15:0] exp_bin);
    logic [3:0] an;
    an = ~(4'b0001 << idx);
    drive_raw(an, ca, n, kind, exp_bin);
  endtask

  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (!reset_i && (valid_o || err_o)) begin
      checks++;
      if (valid_o && err_o) begin
        errors++;
        $display("FAIL exclusive: valid_o=1 err_o=1 at cycle %0d, expected at most one", cyc);
      end else if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: valid_o=%0b err_o=%0b bin_o=%h at cycle %0d, expected none",
                 valid_o, err_o, bin_o, cyc);
      end else begin
        e = q.pop_front();
        if ((valid_o ? 1 : 2) != e.kind || cyc != e.cyc ||
            (valid_o && bin_o !== e.bin)) begin
          errors++;
          $display("FAIL event: kind=%0d bin_o=%h cycle=%0d, expected kind=%0d bin=%h cycle=%0d",
                   valid_o ? 1 : 2, bin_o, cyc, e.kind, e.bin, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i        = 1'b1;
    anode_bits_i   = 4'hF;
    cathode_bits_i = 7'h7F;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      #1;
      anode_bits_i   = 4'($urandom);
      cathode_bits_i = 7'($urandom);
      chk("reset_bin", 32'(bin_o), 32'h0000);
      chk("reset_valid", 32'(valid_o), 32'h0);
      chk("reset_err", 32'(err_o), 32'h0);
    end
    anode_bits_i   = 4'hF;
    cathode_bits_i = 7'h7F;
    reset_i        = 1'b0;
    repeat (2) begin @(posedge clk_i); #1; end

    // Nominal scan of 0xBEEF, 8 cycles per slot
    drive_digit(0, seg(4'hF), 8, 0, 16'h0);
    drive_digit(1, seg(4'hE), 8, 0, 16'h0);
    drive_digit(2, seg(4'hE), 8, 0, 16'h0);
    drive_digit(3, seg(4'hB), 8, 1, 16'hBEEF);
    chk("beef_hold", 32'(bin_o), 32'hBEEF);

    // Glitch on digit 0 held only S-1 cycles must not complete the frame
    drive_digit(1, seg(4'h3), 6, 0, 16'h0);
    drive_digit(2, seg(4'h2), 6, 0, 16'h0);
    drive_digit(3, seg(4'h1), 6, 0, 16'h0);
    drive_digit(0, 7'b1111001, 3, 0, 16'h0);
    drive_digit(0, seg(4'h4), 6, 1, 16'h1234);

    // Undecodable digit 2 pulses err and blocks completion until rescanned
    drive_digit(0, seg(4'h8), 6, 0, 16'h0);
    drive_digit(1, seg(4'h7), 6, 0, 16'h0);
    drive_digit(2, 7'b1010101, 4, 2, 16'h0);
    drive_digit(3, seg(4'h5), 6, 0, 16'h0);
    drive_digit(2, seg(4'h6), 6, 1, 16'h5678);
`ifdef SS_CAPTURE_ERR_CNT_EN
    chk("err_cnt_after_bad", 32'(err_cnt_o), 32'd1);
`endif

    // Two anodes low: ignored entirely
    drive_raw(4'b1100, seg(4'h8), 10, 0, 16'h0);

    // Partial frame discarded by reset
    drive_digit(0, seg(4'h9), 6, 0, 16'h0);
    drive_digit(1, seg(4'h9), 6, 0, 16'h0);
    drive_digit(2, seg(4'h9), 6, 0, 16'h0);
    reset_i        = 1'b1;
    anode_bits_i   = 4'hF;
    cathode_bits_i = 7'h7F;
    repeat (2) begin @(posedge clk_i); #1; end
    chk("midreset_bin", 32'(bin_o), 32'h0000);
`ifdef SS_CAPTURE_ERR_CNT_EN
    chk("midreset_err_cnt", 32'(err_cnt_o), 32'd0);
`endif
    reset_i = 1'b0;
    drive_digit(3, seg(4'hA), 6, 0, 16'h0);
    drive_digit(0, seg(4'h3), 6, 0, 16'h0);
    drive_digit(1, seg(4'hC), 6, 0, 16'h0);
    drive_digit(2, seg(4'h5), 6, 1, 16'hA5C3);

    // Out of order with digit 0 overwritten
    drive_digit(3, seg(4'hC), 6, 0, 16'h0);
    drive_digit(1, seg(4'hD), 6, 0, 16'h0);
    drive_digit(0, seg(4'h1), 6, 0, 16'h0);
    drive_digit(0, seg(4'h9), 6, 0, 16'h0);
    drive_digit(2, seg(4'h0), 6, 1, 16'hC0D9);

    drive_raw(4'hF, 7'h7F, 10, 0, 16'h0);
    chk("final_bin", 32'(bin_o), 32'hC0D9);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
